bpu_pht: RTL and testbench

- Parametrised pattern history table (PHT) for the branch prediction unit.
- Replaces the single 2-bit saturating counter with 2^IDX_W counters, each CNT_W bits wide.
- Indexed by fetch PC, optionally XORed with a global history register (gshare mode).
- Lookup is combinational in the fetch stage; counter training and history update happen at branch resolution via the update port.

---
 rtl/bpu_pht.sv | 51 +++++
 tb/tb_bpu_pht.sv | 127 ++++++++++++
 2 files changed

// File: rtl/bpu_pht.sv
// bpu_pht: pattern history table of saturating counters, bimodal or gshare indexed,
// combinational lookup with read-before-write training at branch resolution.
module bpu_pht #(
   parameter int PC_W     = 32,
   parameter int IDX_W    = 6,
   parameter int CNT_W    = 2,
   parameter int GHR_W    = 0,
   parameter int CNT_INIT = 1,
   localparam int GW      = (GHR_W > 0) ? GHR_W : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [PC_W-1:0]  lkp_pc_i,
   output logic             lkp_pred_o,
   output logic [CNT_W-1:0] lkp_cnt_o,
   output logic [IDX_W-1:0] lkp_idx_o,
   input  logic             upd_vld_i,
   input  logic [IDX_W-1:0] upd_idx_i,
   input  logic             upd_taken_i,
   input  logic             ghr_flush_i,
   output logic [GW-1:0]    ghr_o
);
   localparam int N = 1 << IDX_W;
   localparam logic [CNT_W-1:0] INIT = CNT_INIT[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CMAX = '1;
   logic [CNT_W-1:0] tbl [N];
   logic [GW-1:0]    ghr;
   logic [IDX_W-1:0] hist;
   logic [CNT_W-1:0] cur, nxt;
   logic             unused_pc;
   assign unused_pc  = ^lkp_pc_i;
   assign hist       = (GHR_W > 0) ? IDX_W'(ghr) : '0;
   assign lkp_idx_o  = lkp_pc_i[IDX_W+1:2] ^ hist;
   assign lkp_cnt_o  = tbl[lkp_idx_o];
   assign lkp_pred_o = lkp_cnt_o[CNT_W-1];
   assign ghr_o      = ghr;
   // saturating step; for a 1-bit counter this reduces to taking the outcome
   assign cur = tbl[upd_idx_i];
   assign nxt = upd_taken_i ? ((cur == CMAX) ? cur : cur + 1'b1)
                            : ((cur == '0) ? cur : cur - 1'b1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N; i++) tbl[i] <= INIT;
         ghr <= '0;
      end else begin
         if (upd_vld_i) tbl[upd_idx_i] <= nxt;
         if (ghr_flush_i || GHR_W == 0) ghr <= '0;
         else if (upd_vld_i) ghr <= (ghr << 1) | GW'(upd_taken_i);
      end
   end
endmodule

// File: tb/tb_bpu_pht.sv
// tb_bpu_pht: directed checks of bpu_pht in bimodal (u0) and gshare GHR_W=4 (u1) configurations.
module tb_bpu_pht;
   logic        clk = 0;
   logic        rst0_n, rst1_n;
   logic [31:0] pc0, pc1;
   logic        pred0, pred1;
   logic [1:0]  cnt0, cnt1;
   logic [5:0]  idx0, idx1, uidx0, uidx1;
   logic        vld0, vld1, tk0, tk1, fl0, fl1;
   logic [0:0]  ghr0;
   logic [3:0]  ghr1;
   int          checks = 0, failures = 0;

   always #5 clk = ~clk;

   bpu_pht u0 (
      .clk(clk), .rst_n(rst0_n), .lkp_pc_i(pc0), .lkp_pred_o(pred0), .lkp_cnt_o(cnt0),
      .lkp_idx_o(idx0), .upd_vld_i(vld0), .upd_idx_i(uidx0), .upd_taken_i(tk0),
      .ghr_flush_i(fl0), .ghr_o(ghr0));

   bpu_pht #(.GHR_W(4)) u1 (
      .clk(clk), .rst_n(rst1_n), .lkp_pc_i(pc1), .lkp_pred_o(pred1), .lkp_cnt_o(cnt1),
      .lkp_idx_o(idx1), .upd_vld_i(vld1), .upd_idx_i(uidx1), .upd_taken_i(tk1),
      .ghr_flush_i(fl1), .ghr_o(ghr1));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] up_exp [4] = '{2'd2, 2'd3, 2'd3, 2'd3};
      logic [1:0] dn_exp [5] = '{2'd2, 2'd1, 2'd0, 2'd0, 2'd0};
      logic [3:0] ghr_exp [4] = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};
      logic       tk_seq [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      rst0_n = 0; rst1_n = 0;
      pc0 = 32'h100; pc1 = 32'h100;
      vld0 = 0; vld1 = 0; tk0 = 0; tk1 = 0; fl0 = 0; fl1 = 0; uidx0 = 0; uidx1 = 0;
      tick; tick;
      rst0_n = 1; rst1_n = 1;
      #1;
      // reset defaults
      chk("rst_idx", 32'(idx0), 32'h00);
      chk("rst_cnt", 32'(cnt0), 32'd1);
      chk("rst_pred", 32'(pred0), 32'd0);
      chk("rst_ghr0", 32'(ghr0), 32'd0);
      chk("rst_ghr1", 32'(ghr1), 32'd0);
      // saturation up then down at idx 5
      pc0 = 32'h14; vld0 = 1; uidx0 = 6'd5; tk0 = 1;
      #1;
      chk("pc14_idx", 32'(idx0), 32'd5);
      for (int i = 0; i < 4; i++) begin
         tick;
         chk($sformatf("up%0d_cnt", i), 32'(cnt0), 32'(up_exp[i]));
         chk($sformatf("up%0d_pred", i), 32'(pred0), 32'd1);
      end
      tk0 = 0;
      for (int i = 0; i < 5; i++) begin
         tick;
         chk($sformatf("dn%0d_cnt", i), 32'(cnt0), 32'(dn_exp[i]));
         chk($sformatf("dn%0d_pred", i), 32'(pred0), 32'(dn_exp[i] >= 2'd2));
      end
      // bring to 1, then read-before-write
      tk0 = 1;
      tick;
      chk("rbw_pre", 32'(cnt0), 32'd1);
      tick;
      chk("rbw_next", 32'(cnt0), 32'd2);
      // idle with a live index must not alter state
      vld0 = 0; uidx0 = 6'd5; tk0 = 1;
      tick;
      chk("idle_cnt", 32'(cnt0), 32'd2);
      // reset mid-operation discards a simultaneous update
      pc0 = 32'h1C; vld0 = 1; uidx0 = 6'd7; tk0 = 1;
      tick;
      chk("idx7_cnt", 32'(cnt0), 32'd2);
      rst0_n = 0;
      tick;
      rst0_n = 1; vld0 = 0;
      #1;
      chk("rst_mid_cnt7", 32'(cnt0), 32'd1);
      chk("rst_mid_ghr", 32'(ghr0), 32'd0);
      for (int i = 0; i < 64; i++) begin
         pc0 = 32'(i) << 2;
         #1;
         chk($sformatf("sweep%0d_idx", i), 32'(idx0), 32'(i));
         chk($sformatf("sweep%0d_cnt", i), 32'(cnt0), 32'd1);
      end
      // gshare history build-up, all updates at table[0]
      vld1 = 1; uidx1 = 6'd0;
      for (int i = 0; i < 4; i++) begin
         tk1 = tk_seq[i];
         tick;
         chk($sformatf("ghr_step%0d", i), 32'(ghr1), 32'(ghr_exp[i]));
      end
      vld1 = 0; pc1 = 32'h100;
      #1;
      chk("gs_idx", 32'(idx1), 32'h0B);
      pc1 = 32'h2C;
      #1;
      chk("gs_idx0", 32'(idx1), 32'h00);
      chk("gs_cnt0", 32'(cnt1), 32'd3);
      chk("gs_pred0", 32'(pred1), 32'd1);
      // flush and update in the same cycle
      pc1 = 32'h20;
      #1;
      chk("fl_pre_idx", 32'(idx1), 32'd3);
      chk("fl_pre_cnt", 32'(cnt1), 32'd1);
      vld1 = 1; uidx1 = 6'd3; tk1 = 1; fl1 = 1;
      tick;
      vld1 = 0; fl1 = 0; pc1 = 32'h0C;
      #1;
      chk("fl_ghr", 32'(ghr1), 32'd0);
      chk("fl_idx", 32'(idx1), 32'd3);
      chk("fl_cnt3", 32'(cnt1), 32'd2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
